// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared encodings and types for the ID/EX pipeline register and its
// load-use hazard detector.
//   op_src_e     : which register specifier feeds an operand (Rs/Rt/Rd/none)
//   ops_count_e  : how many operands the instruction actually reads
//   REG_ZERO     : hardwired-zero register number (never a real dependency)
//   idex_ctrl_t  : every non-data field carried from ID into EX
//   CTRL_BUBBLE  : control/specifier pattern of an inserted bubble (a no-op)
// ---------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic [1:0] {
    OP_SRC_RS   = 2'b00,
    OP_SRC_RT   = 2'b01,
    OP_SRC_RD   = 2'b10,
    OP_SRC_NONE = 2'b11
  } op_src_e;

  typedef enum logic [1:0] {
    OPS_NONE = 2'b00,
    OPS_ONE  = 2'b01,
    OPS_TWO  = 2'b10
  } ops_count_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] regDest;
    logic       regWrite;
    logic       memRead;
    logic       storeSignal;
    logic [1:0] op1Src;
    logic [1:0] op2Src;
    logic [1:0] howManyOps;
  } idex_ctrl_t;

  // A bubble has no write, no memory access and all specifiers at r0, so
  // nothing downstream can mistake it for a producer.
  localparam idex_ctrl_t CTRL_BUBBLE = '0;

  // Resolve an operand-source select to the register it names. Returns 0
  // for "none"; callers also gate on the select so r0 is not a false match.
  function automatic logic [4:0] srcReg(input logic [1:0] sel,
                                        input logic [4:0] rs,
                                        input logic [4:0] rt,
                                        input logic [4:0] rd);
    logic [4:0] r;
    r = REG_ZERO;
    case (sel)
      OP_SRC_RS: r = rs;
      OP_SRC_RT: r = rt;
      OP_SRC_RD: r = rd;
      default:   r = REG_ZERO;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// ---------------------------------------------------------------------------
// load_use_detector
// Purely combinational check for a load in EX whose destination is read by
// the instruction currently in ID.
// Ports:
//   ex_mem_read_i      : instruction in EX is a load
//   ex_reg_dest_i      : destination register of the instruction in EX
//   id_rs_i/rt_i/rd_i  : register specifiers of the instruction in ID
//   id_op1_src_i       : source select of operand 1 (op_src_e encoding)
//   id_op2_src_i       : source select of operand 2
//   id_how_many_ops_i  : number of operands actually consumed
//   id_store_i         : ID instruction is a store (reads Rt as data)
//   hazard_o           : 1 = ID must wait one cycle for the load
// ---------------------------------------------------------------------------
module load_use_detector
  import pipeline_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_reg_dest_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic [4:0] id_rd_i,
  input  logic [1:0] id_op1_src_i,
  input  logic [1:0] id_op2_src_i,
  input  logic [1:0] id_how_many_ops_i,
  input  logic       id_store_i,
  output logic       hazard_o
);

  logic useOp1, useOp2;
  logic op1Match, op2Match, storeMatch;

  // Operand 1 counts whenever any operand is read; operand 2 only for
  // two-operand instructions. A "none" select never matches even if the
  // resolved register happens to equal the load destination.
  always_comb begin
    useOp1     = (id_how_many_ops_i != OPS_NONE);
    useOp2     = (id_how_many_ops_i == OPS_TWO);
    op1Match   = (id_op1_src_i != OP_SRC_NONE) &&
                 (srcReg(id_op1_src_i, id_rs_i, id_rt_i, id_rd_i) == ex_reg_dest_i);
    op2Match   = (id_op2_src_i != OP_SRC_NONE) &&
                 (srcReg(id_op2_src_i, id_rs_i, id_rt_i, id_rd_i) == ex_reg_dest_i);
    storeMatch = id_store_i && (id_rt_i == ex_reg_dest_i);
    hazard_o   = ex_mem_read_i && (ex_reg_dest_i != REG_ZERO) &&
                 ((useOp1 && op1Match) || (useOp2 && op2Match) || storeMatch);
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register with load-use stall control and a saturating
// count of inserted bubbles.
// Parameters: DATA_W (operand/immediate width), CNT_W (stall counter width).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : kill the ID instruction (branch/jump redirect)
//   hold              : downstream freeze, ID_EX_* keep their value
//   ID_*              : decoded fields and operand data of the ID instruction
//   ID_EX_*           : registered copies presented to EX and forwarding
//   PC_write          : 0 = hold the PC
//   IF_ID_write       : 0 = hold the IF/ID register
//   stall_cnt         : saturating count of load-use bubbles
// Per-edge priority is flush > hold > hazard > normal capture.
// ---------------------------------------------------------------------------
module id_ex_stage_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              hold,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic [4:0]        ID_Rd,
  input  logic [4:0]        ID_RegDest,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_store_signal,
  input  logic [1:0]        ID_OP1_src,
  input  logic [1:0]        ID_OP2_src,
  input  logic [1:0]        ID_how_many_ops,
  input  logic [DATA_W-1:0] ID_op_a,
  input  logic [DATA_W-1:0] ID_op_b,
  input  logic [DATA_W-1:0] ID_imm,
  output logic [4:0]        ID_EX_Rs,
  output logic [4:0]        ID_EX_Rt,
  output logic [4:0]        ID_EX_Rd,
  output logic [4:0]        ID_EX_RegDest,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_store_signal,
  output logic [1:0]        ID_EX_OP1_src,
  output logic [1:0]        ID_EX_OP2_src,
  output logic [1:0]        ID_EX_how_many_ops,
  output logic [DATA_W-1:0] ID_EX_op_a,
  output logic [DATA_W-1:0] ID_EX_op_b,
  output logic [DATA_W-1:0] ID_EX_imm,
  output logic              PC_write,
  output logic              IF_ID_write,
  output logic [CNT_W-1:0]  stall_cnt
);

  idex_ctrl_t        ctrl_q, ctrl_d, idCtrl;
  logic [DATA_W-1:0] opA_q, opA_d;
  logic [DATA_W-1:0] opB_q, opB_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
  logic              hazard;

  // The comparison uses only registered EX fields and raw ID inputs, so the
  // stall outputs never feed back into their own inputs.
  load_use_detector u_detector (
    .ex_mem_read_i     (ctrl_q.memRead),
    .ex_reg_dest_i     (ctrl_q.regDest),
    .id_rs_i           (ID_Rs),
    .id_rt_i           (ID_Rt),
    .id_rd_i           (ID_Rd),
    .id_op1_src_i      (ID_OP1_src),
    .id_op2_src_i      (ID_OP2_src),
    .id_how_many_ops_i (ID_how_many_ops),
    .id_store_i        (ID_store_signal),
    .hazard_o          (hazard)
  );

  always_comb begin
    idCtrl = '{rs: ID_Rs, rt: ID_Rt, rd: ID_Rd, regDest: ID_RegDest,
               regWrite: ID_RegWrite, memRead: ID_MemRead,
               storeSignal: ID_store_signal, op1Src: ID_OP1_src,
               op2Src: ID_OP2_src, howManyOps: ID_how_many_ops};
  end

  // Next-state selection. Bubbles also zero the data fields so EX never
  // sees stale operands, even though they are don't-care.
  always_comb begin
    ctrl_d     = ctrl_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    imm_d      = imm_q;
    stallCnt_d = stallCnt_q;
    if (flush) begin
      ctrl_d = CTRL_BUBBLE;
      opA_d  = '0;
      opB_d  = '0;
      imm_d  = '0;
    end else if (hold) begin
      // everything keeps its value
    end else if (hazard) begin
      ctrl_d = CTRL_BUBBLE;
      opA_d  = '0;
      opB_d  = '0;
      imm_d  = '0;
      if (stallCnt_q != {CNT_W{1'b1}})
        stallCnt_d = stallCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ctrl_d = idCtrl;
      opA_d  = ID_op_a;
      opB_d  = ID_op_b;
      imm_d  = ID_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= CTRL_BUBBLE;
      opA_q      <= '0;
      opB_q      <= '0;
      imm_q      <= '0;
      stallCnt_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      imm_q      <= imm_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  // Flush redirects fetch so it always lets PC/IF_ID move; otherwise a
  // freeze or a load-use stall holds them. During reset they are released.
  always_comb begin
    PC_write    = !rst_n || flush || !(hold || hazard);
    IF_ID_write = PC_write;
  end

  assign ID_EX_Rs           = ctrl_q.rs;
  assign ID_EX_Rt           = ctrl_q.rt;
  assign ID_EX_Rd           = ctrl_q.rd;
  assign ID_EX_RegDest      = ctrl_q.regDest;
  assign ID_EX_RegWrite     = ctrl_q.regWrite;
  assign ID_EX_MemRead      = ctrl_q.memRead;
  assign ID_EX_store_signal = ctrl_q.storeSignal;
  assign ID_EX_OP1_src      = ctrl_q.op1Src;
  assign ID_EX_OP2_src      = ctrl_q.op2Src;
  assign ID_EX_how_many_ops = ctrl_q.howManyOps;
  assign ID_EX_op_a         = opA_q;
  assign ID_EX_op_b         = opB_q;
  assign ID_EX_imm          = imm_q;
  assign stall_cnt          = stallCnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
// Directed scenarios for the ID/EX register: reset, load-use stall, store
// dependency, r0 destination, flush/hold priority, unused operands,
// back-to-back loads and counter saturation.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, hold;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd, ID_RegDest;
  logic        ID_RegWrite, ID_MemRead, ID_store_signal;
  logic [1:0]  ID_OP1_src, ID_OP2_src, ID_how_many_ops;
  logic [31:0] ID_op_a, ID_op_b, ID_imm;
  logic [4:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_RegDest;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_store_signal;
  logic [1:0]  ID_EX_OP1_src, ID_EX_OP2_src, ID_EX_how_many_ops;
  logic [31:0] ID_EX_op_a, ID_EX_op_b, ID_EX_imm;
  logic        PC_write, IF_ID_write;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] RS = 2'b00, RT = 2'b01, RD = 2'b10, NONE = 2'b11;
  localparam logic [1:0] OPS0 = 2'b00, OPS1 = 2'b01, OPS2 = 2'b10;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_RegDest(ID_RegDest),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_store_signal(ID_store_signal), .ID_OP1_src(ID_OP1_src),
    .ID_OP2_src(ID_OP2_src), .ID_how_many_ops(ID_how_many_ops),
    .ID_op_a(ID_op_a), .ID_op_b(ID_op_b), .ID_imm(ID_imm),
    .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_RegDest(ID_EX_RegDest), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_store_signal(ID_EX_store_signal),
    .ID_EX_OP1_src(ID_EX_OP1_src), .ID_EX_OP2_src(ID_EX_OP2_src),
    .ID_EX_how_many_ops(ID_EX_how_many_ops), .ID_EX_op_a(ID_EX_op_a),
    .ID_EX_op_b(ID_EX_op_b), .ID_EX_imm(ID_EX_imm),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .stall_cnt(stall_cnt)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [4:0] dest,
                               input logic regWrite, input logic memRead,
                               input logic store, input logic [1:0] op1,
                               input logic [1:0] op2, input logic [1:0] ops,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm);
    ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_RegDest = dest;
    ID_RegWrite = regWrite; ID_MemRead = memRead; ID_store_signal = store;
    ID_OP1_src = op1; ID_OP2_src = op2; ID_how_many_ops = ops;
    ID_op_a = a; ID_op_b = b; ID_imm = imm;
  endtask

  // lw rDest, imm(rBase)
  task automatic loadInst(input logic [4:0] dest, input logic [4:0] base);
    applyStimulus(base, dest, 5'd0, dest, 1'b1, 1'b1, 1'b0, RS, NONE, OPS1,
                  32'hA0, 32'h0, 32'h8);
  endtask

  // add r6, r5, r7
  task automatic addDependent();
    applyStimulus(5'd5, 5'd7, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0, RS, RT, OPS2,
                  32'h11, 32'h22, 32'h0);
  endtask

  task automatic nopInst();
    applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RS, RS, OPS0,
                  32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    tick();
    loadInst(5'd5, 5'd1);
    tick();
    addDependent();
    #1;
    checks++;
    if (PC_write !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_prestall_pcw: got %0b want 0", PC_write);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (PC_write !== 1'b1 || IF_ID_write !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_writes: got pc=%0b ifid=%0b want 1/1", PC_write, IF_ID_write);
    end
    checks++;
    if (ID_EX_MemRead !== 1'b0 || ID_EX_RegDest !== 5'd0 || ID_EX_Rs !== 5'd0 || ID_EX_imm !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_regs: got mr=%0b dest=%0d rs=%0d imm=%h want 0", ID_EX_MemRead, ID_EX_RegDest, ID_EX_Rs, ID_EX_imm);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_cnt: got %0d want 0", stall_cnt);
    end
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (ID_EX_RegDest !== 5'd6 || ID_EX_op_a !== 32'h11 || stall_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_no_residual: got dest=%0d a=%h cnt=%0d want 6/11/0", ID_EX_RegDest, ID_EX_op_a, stall_cnt);
    end
  endtask

  task automatic test_load_use();
    nopInst(); tick();
    loadInst(5'd5, 5'd1); tick();
    addDependent();
    #1;
    checks++;
    if (PC_write !== 1'b0 || IF_ID_write !== 1'b0) begin
      errors++; $display("[TB] FAIL loaduse_stall: got pc=%0b ifid=%0b want 0/0", PC_write, IF_ID_write);
    end
    tick();
    checks++;
    if (ID_EX_MemRead !== 1'b0 || ID_EX_RegDest !== 5'd0 || ID_EX_Rs !== 5'd0 || ID_EX_op_a !== 32'd0) begin
      errors++; $display("[TB] FAIL loaduse_bubble: got mr=%0b dest=%0d rs=%0d a=%h want 0", ID_EX_MemRead, ID_EX_RegDest, ID_EX_Rs, ID_EX_op_a);
    end
    checks++;
    if (stall_cnt !== 16'd1 || PC_write !== 1'b1) begin
      errors++; $display("[TB] FAIL loaduse_cnt: got cnt=%0d pc=%0b want 1/1", stall_cnt, PC_write);
    end
    tick();
    checks++;
    if (ID_EX_Rs !== 5'd5 || ID_EX_RegDest !== 5'd6 || ID_EX_op_b !== 32'h22) begin
      errors++; $display("[TB] FAIL loaduse_advance: got rs=%0d dest=%0d b=%h want 5/6/22", ID_EX_Rs, ID_EX_RegDest, ID_EX_op_b);
    end
  endtask

  task automatic test_store();
    loadInst(5'd5, 5'd1); tick();
    applyStimulus(5'd2, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, RS, NONE, OPS1,
                  32'h2, 32'h55, 32'h4);
    #1;
    checks++;
    if (PC_write !== 1'b0) begin
      errors++; $display("[TB] FAIL store_stall: got %0b want 0", PC_write);
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd2) begin
      errors++; $display("[TB] FAIL store_cnt: got %0d want 2", stall_cnt);
    end
    tick();
    checks++;
    if (ID_EX_store_signal !== 1'b1 || ID_EX_Rt !== 5'd5) begin
      errors++; $display("[TB] FAIL store_advance: got st=%0b rt=%0d want 1/5", ID_EX_store_signal, ID_EX_Rt);
    end
  endtask

  task automatic test_reg_zero();
    loadInst(5'd0, 5'd1); tick();
    applyStimulus(5'd0, 5'd7, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0, RS, RT, OPS2,
                  32'h1, 32'h2, 32'h0);
    #1;
    checks++;
    if (PC_write !== 1'b1) begin
      errors++; $display("[TB] FAIL regzero_nostall: got %0b want 1", PC_write);
    end
    tick();
    checks++;
    if (ID_EX_RegDest !== 5'd6 || stall_cnt !== 16'd2) begin
      errors++; $display("[TB] FAIL regzero_advance: got dest=%0d cnt=%0d want 6/2", ID_EX_RegDest, stall_cnt);
    end
  endtask

  task automatic test_flush();
    loadInst(5'd5, 5'd1); tick();
    addDependent();
    flush = 1'b1;
    #1;
    checks++;
    if (PC_write !== 1'b1 || IF_ID_write !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_writes: got pc=%0b ifid=%0b want 1/1", PC_write, IF_ID_write);
    end
    tick();
    checks++;
    if (ID_EX_RegDest !== 5'd0 || ID_EX_RegWrite !== 1'b0 || stall_cnt !== 16'd2) begin
      errors++; $display("[TB] FAIL flush_bubble: got dest=%0d rw=%0b cnt=%0d want 0/0/2", ID_EX_RegDest, ID_EX_RegWrite, stall_cnt);
    end
    flush = 1'b0;
  endtask

  task automatic test_hold();
    loadInst(5'd5, 5'd1); tick();
    addDependent();
    hold = 1'b1;
    #1;
    checks++;
    if (PC_write !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_pcw: got %0b want 0", PC_write);
    end
    tick();
    checks++;
    if (ID_EX_MemRead !== 1'b1 || ID_EX_RegDest !== 5'd5 || ID_EX_imm !== 32'h8 || stall_cnt !== 16'd2) begin
      errors++; $display("[TB] FAIL hold_frozen: got mr=%0b dest=%0d imm=%h cnt=%0d want 1/5/8/2", ID_EX_MemRead, ID_EX_RegDest, ID_EX_imm, stall_cnt);
    end
    hold = 1'b0;
    tick();
    checks++;
    if (stall_cnt !== 16'd3 || ID_EX_MemRead !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_release_stall: got cnt=%0d mr=%0b want 3/0", stall_cnt, ID_EX_MemRead);
    end
    tick();
    checks++;
    if (ID_EX_RegDest !== 5'd6) begin
      errors++; $display("[TB] FAIL hold_advance: got %0d want 6", ID_EX_RegDest);
    end
  endtask

  task automatic test_unused_op();
    loadInst(5'd5, 5'd1); tick();
    applyStimulus(5'd5, 5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, RT, RS, OPS1,
                  32'h3, 32'h4, 32'h0);
    #1;
    checks++;
    if (PC_write !== 1'b1) begin
      errors++; $display("[TB] FAIL unused_op2: got %0b want 1", PC_write);
    end
    applyStimulus(5'd5, 5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, NONE, RT, OPS2,
                  32'h3, 32'h4, 32'h0);
    #1;
    checks++;
    if (PC_write !== 1'b1) begin
      errors++; $display("[TB] FAIL unused_src_none: got %0b want 1", PC_write);
    end
    applyStimulus(5'd5, 5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, RS, RS, OPS0,
                  32'h3, 32'h4, 32'h0);
    #1;
    checks++;
    if (PC_write !== 1'b1) begin
      errors++; $display("[TB] FAIL unused_no_ops: got %0b want 1", PC_write);
    end
    tick();
    checks++;
    if (ID_EX_RegDest !== 5'd9 || stall_cnt !== 16'd3) begin
      errors++; $display("[TB] FAIL unused_advance: got dest=%0d cnt=%0d want 9/3", ID_EX_RegDest, stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    loadInst(5'd5, 5'd1); tick();
    loadInst(5'd6, 5'd5);
    #1;
    checks++;
    if (PC_write !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_first_stall: got %0b want 0", PC_write);
    end
    tick();
    tick();
    checks++;
    if (ID_EX_RegDest !== 5'd6 || ID_EX_MemRead !== 1'b1 || stall_cnt !== 16'd4) begin
      errors++; $display("[TB] FAIL b2b_second_load: got dest=%0d mr=%0b cnt=%0d want 6/1/4", ID_EX_RegDest, ID_EX_MemRead, stall_cnt);
    end
    // Operand 2 selects Rd = r6, the second load's destination.
    applyStimulus(5'd1, 5'd2, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, RS, RD, OPS2,
                  32'h5, 32'h6, 32'h0);
    #1;
    checks++;
    if (PC_write !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_rd_stall: got %0b want 0", PC_write);
    end
    tick();
    tick();
    checks++;
    if (ID_EX_RegDest !== 5'd7 || stall_cnt !== 16'd5) begin
      errors++; $display("[TB] FAIL b2b_advance: got dest=%0d cnt=%0d want 7/5", ID_EX_RegDest, stall_cnt);
    end
  endtask

  task automatic test_saturate();
    loadInst(5'd5, 5'd1); tick();
    force dut.stallCnt_q = 16'hFFFF;
    #1 release dut.stallCnt_q;
    addDependent();
    #1;
    checks++;
    if (PC_write !== 1'b0) begin
      errors++; $display("[TB] FAIL sat_stall: got %0b want 0", PC_write);
    end
    tick();
    checks++;
    if (stall_cnt !== 16'hFFFF || ID_EX_MemRead !== 1'b0) begin
      errors++; $display("[TB] FAIL sat_cnt: got cnt=%h mr=%0b want ffff/0", stall_cnt, ID_EX_MemRead);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    hold  = 1'b0;
    nopInst();
    #12 rst_n = 1'b1;
    test_reset();
    test_load_use();
    test_store();
    test_reg_zero();
    test_flush();
    test_hold();
    test_unused_op();
    test_back_to_back();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
